// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard/mouse event queue.
//   - cap_state_t : capture FSM state encoding (IDLE, ACK, WAIT_LOW)
//   - KBD_ENTRY_W : width of one queue entry (mouse flag + 16-bit data)
//   - kbd_entry_t : packed entry layout, bit 16 mouse flag, bits 15:0 data
//   - make_entry  : builds an entry from its fields
package kbd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACK      = 2'd1,
      ST_WAIT_LOW = 2'd2
   } cap_state_t;

   localparam int KBD_DATA_W    = 16;
   localparam int KBD_ENTRY_W   = 17;
   localparam int KBD_MOUSE_BIT = 16;

   // Field order fixes the bit positions: is_mouse lands on bit 16.
   typedef struct packed {
      logic                  is_mouse;
      logic [KBD_DATA_W-1:0] data;
   } kbd_entry_t;

   function automatic kbd_entry_t make_entry(input logic is_mouse,
                                             input logic [KBD_DATA_W-1:0] data);
      kbd_entry_t e;
      e.is_mouse = is_mouse;
      e.data     = data;
      return e;
   endfunction

endpackage

// File: rtl/kbd_fifo.sv
// First-word-fall-through FIFO for captured input events.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : synchronous clear of pointers and count (beats push/pop)
//   push         : push attempt with wr_data
//   pop_ready    : consumer takes the head entry when valid is high
//   rd_data      : registered head entry
//   valid / full : queue non-empty / queue holds DEPTH entries
//   pop          : a pop happens this cycle
//   push_accept  : the push attempt is stored this cycle
//   push_drop    : the push attempt is lost because the queue is full
// DEPTH must be a power of two (>= 2) so pointers wrap naturally.
module kbd_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             valid,
   output logic             full,
   output logic             pop,
   output logic             push_accept,
   output logic             push_drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_next;
   logic [CNT_W-1:0] count_q, count_next;
   logic [WIDTH-1:0] head_next;
   logic             head_load;

   assign valid       = (count_q != '0);
   assign full        = (count_q == CNT_FULL);
   assign pop         = valid && pop_ready;
   // A pop frees a slot in the same cycle, so a full queue still accepts.
   assign push_accept = push && (!full || pop);
   assign push_drop   = push && !push_accept;

   // NOTE: every combinational output gets a default first so no path
   // leaves a value unassigned, which would otherwise infer a latch.
   always_comb begin
      wr_ptr_next = wr_ptr_q;
      rd_ptr_next = rd_ptr_q;
      count_next  = count_q;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (push_accept) wr_ptr_next = wr_ptr_q + PTR_W'(1);
         if (pop)         rd_ptr_next = rd_ptr_q + PTR_W'(1);
         unique case ({push_accept, pop})
            2'b10:   count_next = count_q + CNT_W'(1);
            2'b01:   count_next = count_q - CNT_W'(1);
            default: count_next = count_q;
         endcase
      end
   end

   // The next head is either already in storage or is the word being
   // written this cycle (empty queue, or a pop that drains the last entry
   // while a new one arrives). Hold the old head when the queue empties.
   always_comb begin
      head_load = !flush && (count_next != '0);
      if (push_accept && (rd_ptr_next == wr_ptr_q)) head_next = wr_data;
      else                                          head_next = mem[rd_ptr_next];
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rd_data  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_next;
         rd_ptr_q <= rd_ptr_next;
         count_q  <= count_next;
         if (head_load) rd_data <= head_next;
      end
   end

   // NOTE: storage is deliberately left out of reset; the count decides
   // which words are meaningful, and a resettable array costs a lot.
   always_ff @(posedge clk) begin
      if (push_accept && !flush) mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/kbd_event_queue.sv
// Keyboard/mouse event queue between the keyboard receiver and the host.
//   clk, rst_n      : clock shared with the receiver, async active-low reset
//   kb_data_ready   : receiver has an event pending (level)
//   kb_is_mouse     : event source, 0 keyboard / 1 mouse
//   kb_data         : 16-bit scan word or mouse delta word
//   kb_retrieved    : one-cycle acknowledge back to the receiver
//   out_valid       : queue non-empty
//   out_ready       : host consumes the head entry this cycle
//   out_data        : head entry data word
//   out_is_mouse    : head entry source flag
//   flush           : synchronous queue clear (also clears overflow_cnt)
//   irq_en, irq     : interrupt enable, registered out_valid & irq_en
//   overflow_cnt    : saturating count of events dropped on a full queue
module kbd_event_queue
   import kbd_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  kb_data_ready,
   input  logic                  kb_is_mouse,
   input  logic [KBD_DATA_W-1:0] kb_data,
   output logic                  kb_retrieved,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [KBD_DATA_W-1:0] out_data,
   output logic                  out_is_mouse,
   input  logic                  flush,
   input  logic                  irq_en,
   output logic                  irq,
   output logic [7:0]            overflow_cnt
);

   localparam logic [7:0] OVF_MAX = 8'hFF;

   cap_state_t state_q, state_next;
   logic       capture;
   kbd_entry_t wr_entry;
   kbd_entry_t rd_entry;
   logic       fifo_full;
   logic       fifo_pop;
   logic       push_accept;
   logic       push_drop;

   // ---------------- capture FSM ----------------
   // Only IDLE samples the receiver, so one kb_data_ready assertion yields
   // exactly one push attempt however long the level stays high.
   assign capture      = (state_q == ST_IDLE) && kb_data_ready;
   assign kb_retrieved = (state_q == ST_ACK);
   assign wr_entry     = make_entry(kb_is_mouse, kb_data);

   always_comb begin
      state_next = state_q;
      unique case (state_q)
         ST_IDLE:     if (kb_data_ready)  state_next = ST_ACK;
         ST_ACK:                          state_next = ST_WAIT_LOW;
         ST_WAIT_LOW: if (!kb_data_ready) state_next = ST_IDLE;
         default:                         state_next = ST_IDLE;
      endcase
   end

   // Reset returns straight to IDLE, abandoning any handshake, so a level
   // still held after release is taken as a fresh event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_next;
   end

   // ---------------- storage ----------------
   kbd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (KBD_ENTRY_W)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .push        (capture),
      .pop_ready   (out_ready),
      .wr_data     (wr_entry),
      .rd_data     (rd_entry),
      .valid       (out_valid),
      .full        (fifo_full),
      .pop         (fifo_pop),
      .push_accept (push_accept),
      .push_drop   (push_drop)
   );

   assign out_data     = rd_entry.data;
   assign out_is_mouse = rd_entry.is_mouse;

   // ---------------- overflow counter ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_cnt <= '0;
      end else if (flush) begin
         overflow_cnt <= '0;
      end else if (push_drop && (overflow_cnt != OVF_MAX)) begin
         overflow_cnt <= overflow_cnt + 8'd1;
      end
   end

   // ---------------- interrupt ----------------
   // Flush also forces irq low so it drops together with out_valid instead
   // of lingering one extra cycle on the pre-flush queue state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq <= 1'b0;
      else        irq <= out_valid && irq_en && !flush;
   end

endmodule

// File: tb/tb_kbd_event_queue.sv
// Directed self-checking bench for kbd_event_queue (DEPTH = 8).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_kbd_event_queue;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        kb_data_ready = 1'b0;
   logic        kb_is_mouse = 1'b0;
   logic [15:0] kb_data = '0;
   logic        out_ready = 1'b0;
   logic        flush = 1'b0;
   logic        irq_en = 1'b0;
   logic        kb_retrieved;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_is_mouse;
   logic        irq;
   logic [7:0]  overflow_cnt;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   kbd_event_queue #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .kb_data_ready (kb_data_ready),
      .kb_is_mouse   (kb_is_mouse),
      .kb_data       (kb_data),
      .kb_retrieved  (kb_retrieved),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_is_mouse  (out_is_mouse),
      .flush         (flush),
      .irq_en        (irq_en),
      .irq           (irq),
      .overflow_cnt  (overflow_cnt)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   // Receiver model: raise ready, wait (bounded) for the acknowledge, drop
   // ready, and let the FSM return to IDLE before the next event.
   task automatic send_event(input logic [15:0] d, input logic m);
      bit seen;
      seen = 1'b0;
      kb_data = d;
      kb_is_mouse = m;
      kb_data_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (kb_retrieved === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      n_compared++;
      if (!seen) begin
         n_mismatched++;
         $display("FAIL ack_timeout: data %h got no kb_retrieved, required one within 8 cycles", d);
      end
      kb_data_ready = 1'b0;
      tick();
      n_compared++;
      if (kb_retrieved !== 1'b0) begin
         n_mismatched++;
         $display("FAIL ack_width: kb_retrieved=%b required 0 one cycle after ack", kb_retrieved);
      end
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_compared++;
      if ({kb_retrieved, out_valid, out_is_mouse, irq} !== 4'b0000) begin
         n_mismatched++;
         $display("FAIL reset_flags: {ret,valid,mouse,irq}=%b required 0000",
                  {kb_retrieved, out_valid, out_is_mouse, irq});
      end
      n_compared++;
      if (out_data !== 16'h0000) begin
         n_mismatched++;
         $display("FAIL reset_data: out_data=%h required 0000", out_data);
      end
      n_compared++;
      if (overflow_cnt !== 8'h00) begin
         n_mismatched++;
         $display("FAIL reset_ovf: overflow_cnt=%0d required 0", overflow_cnt);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int pulses;
      bit seen;
      pulses = 0;
      seen = 1'b0;
      kb_data = 16'h1A2B;
      kb_is_mouse = 1'b0;
      kb_data_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (kb_retrieved === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      n_compared++;
      if (!seen) begin
         n_mismatched++;
         $display("FAIL single_ack: no kb_retrieved, required one pulse");
      end
      // Entry becomes visible on the same edge as the acknowledge.
      n_compared++;
      if (out_valid !== 1'b1) begin
         n_mismatched++;
         $display("FAIL single_valid: out_valid=%b required 1", out_valid);
      end
      kb_data_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (kb_retrieved === 1'b1) pulses++;
      end
      n_compared++;
      if (pulses != 0) begin
         n_mismatched++;
         $display("FAIL single_extra_ack: %0d extra pulses required 0", pulses);
      end
      n_compared++;
      if ({out_valid, out_is_mouse, out_data} !== {1'b1, 1'b0, 16'h1A2B}) begin
         n_mismatched++;
         $display("FAIL single_head: valid=%b mouse=%b data=%h required 1 0 1a2b",
                  out_valid, out_is_mouse, out_data);
      end
      pop_one();
      n_compared++;
      if (out_valid !== 1'b0) begin
         n_mismatched++;
         $display("FAIL single_pop: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= DEPTH; i++) send_event(16'(i), 1'b0);
      n_compared++;
      if (overflow_cnt !== 8'd0 || out_data !== 16'h0001) begin
         n_mismatched++;
         $display("FAIL fill_full: ovf=%0d head=%h required 0 0001", overflow_cnt, out_data);
      end
      send_event(16'h0009, 1'b0);
      n_compared++;
      if (overflow_cnt !== 8'd1) begin
         n_mismatched++;
         $display("FAIL fill_ovf: overflow_cnt=%0d required 1", overflow_cnt);
      end
      for (int k = 1; k <= DEPTH; k++) begin
         n_compared++;
         if (out_valid !== 1'b1 || out_data !== 16'(k)) begin
            n_mismatched++;
            $display("FAIL fill_drain: valid=%b data=%h required 1 %h", out_valid, out_data, 16'(k));
         end
         pop_one();
      end
      n_compared++;
      if (out_valid !== 1'b0) begin
         n_mismatched++;
         $display("FAIL fill_empty: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_full_push_pop();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_compared++;
      if (overflow_cnt !== 8'd0 || out_valid !== 1'b0) begin
         n_mismatched++;
         $display("FAIL flush_clear: ovf=%0d valid=%b required 0 0", overflow_cnt, out_valid);
      end
      for (int i = 0; i < DEPTH; i++) send_event(16'h0010 + 16'(i), 1'(i % 2));
      // Push and pop on the same edge while full.
      kb_data = 16'h0018;
      kb_is_mouse = 1'b0;
      kb_data_ready = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_compared++;
      if (kb_retrieved !== 1'b1 || overflow_cnt !== 8'd0 || out_data !== 16'h0011) begin
         n_mismatched++;
         $display("FAIL fullpp_step: ret=%b ovf=%0d head=%h required 1 0 0011",
                  kb_retrieved, overflow_cnt, out_data);
      end
      kb_data_ready = 1'b0;
      tick();
      tick();
      for (int k = 1; k <= DEPTH; k++) begin
         n_compared++;
         if (out_valid !== 1'b1 || out_data !== 16'h0010 + 16'(k) || out_is_mouse !== 1'(k % 2)) begin
            n_mismatched++;
            $display("FAIL fullpp_drain: valid=%b mouse=%b data=%h required 1 %b %h",
                     out_valid, out_is_mouse, out_data, 1'(k % 2), 16'h0010 + 16'(k));
         end
         pop_one();
      end
      n_compared++;
      if (out_valid !== 1'b0) begin
         n_mismatched++;
         $display("FAIL fullpp_empty: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_wrap();
      logic [16:0] q[$];
      logic [15:0] d;
      logic        m;
      send_event(16'h0200, 1'b0);
      q.push_back({1'b0, 16'h0200});
      for (int i = 1; i <= 20; i++) begin
         d = 16'h0200 + 16'(i);
         m = 1'(i % 2);
         kb_data = d;
         kb_is_mouse = m;
         kb_data_ready = 1'b1;
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         void'(q.pop_front());
         q.push_back({m, d});
         n_compared++;
         if (kb_retrieved !== 1'b1 || {out_is_mouse, out_data} !== q[0]) begin
            n_mismatched++;
            $display("FAIL wrap_head: ret=%b entry=%h required 1 %h",
                     kb_retrieved, {out_is_mouse, out_data}, q[0]);
         end
         kb_data_ready = 1'b0;
         tick();
         tick();
      end
      n_compared++;
      if (overflow_cnt !== 8'd0) begin
         n_mismatched++;
         $display("FAIL wrap_ovf: overflow_cnt=%0d required 0", overflow_cnt);
      end
      n_compared++;
      if (out_valid !== 1'b1 || {out_is_mouse, out_data} !== q[0]) begin
         n_mismatched++;
         $display("FAIL wrap_last: valid=%b entry=%h required 1 %h",
                  out_valid, {out_is_mouse, out_data}, q[0]);
      end
      pop_one();
      n_compared++;
      if (out_valid !== 1'b0) begin
         n_mismatched++;
         $display("FAIL wrap_empty: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_flush_irq();
      irq_en = 1'b1;
      send_event(16'h0301, 1'b0);
      send_event(16'h0302, 1'b1);
      send_event(16'h0303, 1'b0);
      n_compared++;
      if (irq !== 1'b1) begin
         n_mismatched++;
         $display("FAIL flush_pre_irq: irq=%b required 1", irq);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_compared++;
      if (out_valid !== 1'b0 || irq !== 1'b0) begin
         n_mismatched++;
         $display("FAIL flush_post: valid=%b irq=%b required 0 0", out_valid, irq);
      end
      tick();
      n_compared++;
      if (out_valid !== 1'b0 || irq !== 1'b0) begin
         n_mismatched++;
         $display("FAIL flush_hold: valid=%b irq=%b required 0 0", out_valid, irq);
      end
      irq_en = 1'b0;
      tick();
   endtask

   task automatic test_irq();
      irq_en = 1'b1;
      kb_data = 16'h55AA;
      kb_is_mouse = 1'b1;
      kb_data_ready = 1'b1;
      tick();
      kb_data_ready = 1'b0;
      n_compared++;
      if (out_valid !== 1'b1 || irq !== 1'b0) begin
         n_mismatched++;
         $display("FAIL irq_lag_rise: valid=%b irq=%b required 1 0", out_valid, irq);
      end
      tick();
      n_compared++;
      if (irq !== 1'b1) begin
         n_mismatched++;
         $display("FAIL irq_rise: irq=%b required 1", irq);
      end
      tick();
      pop_one();
      n_compared++;
      if (out_valid !== 1'b0 || irq !== 1'b1) begin
         n_mismatched++;
         $display("FAIL irq_lag_fall: valid=%b irq=%b required 0 1", out_valid, irq);
      end
      tick();
      n_compared++;
      if (irq !== 1'b0) begin
         n_mismatched++;
         $display("FAIL irq_fall: irq=%b required 0", irq);
      end
      irq_en = 1'b0;
   endtask

   task automatic test_saturate();
      for (int i = 0; i < DEPTH; i++) send_event(16'h0400 + 16'(i), 1'b0);
      for (int i = 0; i < 260; i++) send_event(16'h0500, 1'b1);
      n_compared++;
      if (overflow_cnt !== 8'd255) begin
         n_mismatched++;
         $display("FAIL ovf_saturate: overflow_cnt=%0d required 255", overflow_cnt);
      end
      n_compared++;
      if (out_valid !== 1'b1 || out_data !== 16'h0400) begin
         n_mismatched++;
         $display("FAIL ovf_head: valid=%b data=%h required 1 0400", out_valid, out_data);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_compared++;
      if (overflow_cnt !== 8'd0 || out_valid !== 1'b0) begin
         n_mismatched++;
         $display("FAIL ovf_flush: ovf=%0d valid=%b required 0 0", overflow_cnt, out_valid);
      end
   endtask

   task automatic test_reset_mid_ack();
      kb_data = 16'hBEEF;
      kb_is_mouse = 1'b1;
      kb_data_ready = 1'b1;
      tick();
      n_compared++;
      if (kb_retrieved !== 1'b1) begin
         n_mismatched++;
         $display("FAIL rst_ack_start: kb_retrieved=%b required 1", kb_retrieved);
      end
      rst_n = 1'b0;
      #1;
      n_compared++;
      if (kb_retrieved !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
         n_mismatched++;
         $display("FAIL rst_abandon: ret=%b valid=%b data=%h required 0 0 0000",
                  kb_retrieved, out_valid, out_data);
      end
      tick();
      rst_n = 1'b1;
      tick();
      n_compared++;
      if (kb_retrieved !== 1'b1 || out_valid !== 1'b1 ||
          out_data !== 16'hBEEF || out_is_mouse !== 1'b1) begin
         n_mismatched++;
         $display("FAIL rst_recapture: ret=%b valid=%b mouse=%b data=%h required 1 1 1 beef",
                  kb_retrieved, out_valid, out_is_mouse, out_data);
      end
      kb_data_ready = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_full_push_pop();
      test_wrap();
      test_flush_irq();
      test_irq();
      test_saturate();
      test_reset_mid_ack();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/kbd_event_queue.md
KBD_EVENT_QUEUE -- requirements
Module: kbd_event_queue

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  monitor clock, shared with the keyboard receiver; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 kb_data_ready  input  1  event-pending level from the keyboard receiver.
REQ-005 kb_is_mouse  input  1  event source: 0 keyboard, 1 mouse.
REQ-006 kb_data  input  16  keyboard scan word or mouse delta word.
REQ-007 kb_retrieved  output  1  one-cycle acknowledge to the receiver; receiver clears kb_data_ready on the following edge.
REQ-008 out_valid  output  1  queue non-empty.
REQ-009 out_ready  input  1  host consumes head entry this cycle.
REQ-010 out_data  output  16  head entry data word.
REQ-011 out_is_mouse  output  1  head entry source flag.
REQ-012 flush  input  1  synchronous queue clear.
REQ-013 irq_en  input  1  interrupt enable.
REQ-014 irq  output  1  registered: out_valid AND irq_en.
REQ-015 overflow_cnt  output  8  saturating count of dropped events.

Function
REQ-016 Capture FSM states: IDLE, ACK, WAIT_LOW.
- IDLE: on kb_data_ready=1, go to ACK.
- ACK: kb_retrieved=1 for exactly this cycle; go to WAIT_LOW.
- WAIT_LOW: stay until kb_data_ready=0, then go to IDLE.
REQ-017 Push uses {kb_is_mouse, kb_data} sampled in the IDLE cycle that detects kb_data_ready.
- Entry is visible on out_valid one cycle after that cycle.
- kb_retrieved asserts on the same edge.
REQ-018 kb_retrieved SHALL be a state decode (state==ACK) and never assert in any other state.
REQ-019 Each kb_data_ready assertion SHALL produce exactly one push attempt; no duplicate capture while in ACK or WAIT_LOW.
REQ-020 Full handling:
- Event is still acknowledged but not stored.
- overflow_cnt increments, saturating at 255.
- If a pop occurs in the same cycle as a push while full, the push SHALL be accepted and the count is unchanged.
REQ-021 Pop occurs when out_valid AND out_ready. out_data/out_is_mouse are first-word-fall-through, registered from FIFO storage, stable while out_valid=1 and no pop.
REQ-022 Simultaneous push and pop with count between 1 and DEPTH-1 SHALL leave the count unchanged. Push into an empty queue with out_ready=1 SHALL NOT pop in the same cycle.
REQ-023 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits; full is count==DEPTH, empty is count==0.
REQ-024 flush has priority over push and pop.
- Next cycle: count=0, pointers=0, out_valid=0.
- overflow_cnt is cleared.
- Capture FSM is unaffected, and an acknowledge in progress completes.
REQ-025 irq updates one cycle after out_valid or irq_en changes.

Reset
REQ-026 With rst_n=0, outputs SHALL be: kb_retrieved=0, out_valid=0, out_data=0, out_is_mouse=0, irq=0, overflow_cnt=0.
REQ-027 With rst_n=0, internal state SHALL be: FSM=IDLE, pointers=0, count=0.
REQ-028 Reset asserted mid-handshake SHALL abandon it without a kb_retrieved pulse. After release, a still-high kb_data_ready SHALL be captured as a new event.
REQ-029 FIFO storage contents need no reset.

Structure
REQ-030 Shared package kbd_pkg SHALL hold:
- FSM state encoding.
- Entry width constant KBD_ENTRY_W=17.
- Entry field positions: bit 16 mouse flag, bits 15:0 data.
REQ-031 Storage and pointer/count logic SHALL be a sub-module kbd_fifo, parameterised on DEPTH and width. kbd_event_queue holds the capture FSM, the overflow counter and irq.

Verification
REQ-032 Single event: drive kb_data=16'h1A2B, kb_is_mouse=0, data_ready high, then drop it one cycle after kb_retrieved -> exactly one kb_retrieved pulse; out_valid next cycle; out_data=16'h1A2B; out_is_mouse=0.
REQ-033 Fill: push 8 events 0x0001..0x0008 with out_ready=0, then a 9th 0x0009 -> 9 acknowledges; overflow_cnt=1; draining yields 1..8 in order; then out_valid=0.
REQ-034 Full push plus pop: at count 8, assert a push and out_ready in the same cycle -> count stays 8; head advances; new entry appears last.
REQ-035 Wrap-around: 20 interleaved push/pop pairs with alternating mouse flag -> output order and flags match input exactly; no spurious overflow.
REQ-036 Flush and reset: with 3 entries queued, pulse flush -> out_valid=0 and irq=0 next cycle. Assert rst_n=0 during ACK -> kb_retrieved=0 immediately; held data_ready is re-captured after release.
REQ-037 Interrupt: irq_en=1, push one entry -> irq rises one cycle after out_valid; pop it -> irq falls one cycle later.
